// File: rtl/uart_ctrl_pkg.sv
// Shared UART controller constants and types, used by the TX FIFO and
// reused by the RX FIFO.
package uart_ctrl_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_DATA_W     = 8;

  typedef logic [4:0] uart_fifo_cnt_t;

endpackage

// File: rtl/uart_ctrl_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array with a synchronous write port
// and an asynchronous read port. Contents are intentionally never reset.
module uart_ctrl_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_ctrl_tx_fifo.sv
// UART transmit FIFO, first-word-fall-through, with live occupancy and a
// sticky overflow flag. Pointer/count logic is shared in shape with the RX FIFO.
module uart_ctrl_tx_fifo
  import uart_ctrl_pkg::*;
#(
  parameter int  DATA_W = UART_DATA_W,
  parameter int  DEPTH  = UART_FIFO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       fifo_ptr,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push_acc;
  logic          pop_acc;

  // Flags decode only the registered count, so wr_en/rd_en never reach them.
  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign fifo_ptr = cnt;

  assign push_acc = wr_en && !full  && !clr;
  assign pop_acc  = rd_en && !empty && !clr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A dropped push outranks a simultaneous LSR read so the event is not lost.
  always_ff @(posedge clock) begin
    if (reset)                         overflow <= 1'b0;
    else if (wr_en && full && !clr)    overflow <= 1'b1;
    else if (ovf_clr)                  overflow <= 1'b0;
  end

  uart_ctrl_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .we    (push_acc && !reset),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

endmodule
